// File: rtl/svf_pwm_out_if.sv
// ---------------------------------------------------------------------------
// svf_pwm_out_if
// Sample-set handshake between the state-variable filter core and its PWM
// output stage.
//
//   in_valid    master -> slave  sample set on yh/yb/yl/yn is valid
//   in_ready    slave  -> master output stage can take a sample this cycle
//   mode        master -> slave  response select: 0=LP, 1=BP, 2=HP, 3=notch
//   gain_shift  master -> slave  left shift 0..3 applied before saturation
//   yh/yb/yl/yn master -> slave  signed filter outputs, WIDTH bits each
// ---------------------------------------------------------------------------
interface svf_pwm_out_if #(
  parameter int WIDTH = 12
);
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              mode;
  logic [1:0]              gain_shift;
  logic signed [WIDTH-1:0] yh;
  logic signed [WIDTH-1:0] yb;
  logic signed [WIDTH-1:0] yl;
  logic signed [WIDTH-1:0] yn;

  modport master (
    output in_valid,
    output mode,
    output gain_shift,
    output yh,
    output yb,
    output yl,
    output yn,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  mode,
    input  gain_shift,
    input  yh,
    input  yb,
    input  yl,
    input  yn,
    output in_ready
  );
endinterface

// File: rtl/svf_pwm_out.sv
// ---------------------------------------------------------------------------
// svf_pwm_out
// Output stage of the state-variable filter. Takes one sample set per
// handshake, picks the response selected by mode, applies a saturating
// power-of-two gain, converts to offset binary and drives a single-bit PWM
// pin whose period is 2^WIDTH clocks. The duty is double-buffered: a new
// sample waits in a pending register and is promoted to the active duty only
// on the last cycle of a PWM period, so the pin never glitches mid-period.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   s_if          sample handshake (slave side): in_valid/in_ready, mode,
//                 gain_shift, yh/yb/yl/yn
//   pwm_out       registered PWM pin
//   sample_taken  one-cycle pulse after a pending sample became the duty
//   duty          active duty value, offset binary (debug visibility)
// ---------------------------------------------------------------------------
module svf_pwm_out #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  svf_pwm_out_if.slave     s_if,
  output logic             pwm_out,
  output logic             sample_taken,
  output logic [WIDTH-1:0] duty
);

  // Three guard bits hold the largest shift (x8) without overflow.
  localparam int EXT_W = WIDTH + 3;

  localparam logic signed [EXT_W-1:0] SAT_MAX = {4'b0000, {(WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {4'b1111, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]        DUTY_MID = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]        CNT_LAST = {WIDTH{1'b1}};

  // State
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] r_pending;
  logic             r_pending_full;
  logic             r_pwm;
  logic             r_taken;

  // Datapath
  logic signed [WIDTH-1:0] w_sel;
  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_shifted;
  logic signed [WIDTH-1:0] w_sat;
  logic [WIDTH-1:0]        w_offset;

  // Control
  logic w_wrap;
  logic w_accept;
  logic w_load;

  // -------------------------------------------------------------------------
  // Response select, gain and saturation. Evaluated every cycle but only
  // captured on an accept, so mode/gain_shift matter only at that edge.
  // -------------------------------------------------------------------------
  always_comb begin
    w_sel = s_if.yl;
    case (s_if.mode)
      2'd0:    w_sel = s_if.yl;
      2'd1:    w_sel = s_if.yb;
      2'd2:    w_sel = s_if.yh;
      default: w_sel = s_if.yn;
    endcase
  end

  assign w_ext     = {{3{w_sel[WIDTH-1]}}, w_sel};
  assign w_shifted = w_ext <<< s_if.gain_shift;

  always_comb begin
    w_sat = w_shifted[WIDTH-1:0];
    if (w_shifted > SAT_MAX) begin
      w_sat = SAT_MAX[WIDTH-1:0];
    end else if (w_shifted < SAT_MIN) begin
      w_sat = SAT_MIN[WIDTH-1:0];
    end
  end

  // Offset binary: flipping the sign bit maps -2^(W-1)..2^(W-1)-1 onto 0..2^W-1.
  assign w_offset = {~w_sat[WIDTH-1], w_sat[WIDTH-2:0]};

  // -------------------------------------------------------------------------
  // Handshake and double-buffer control.
  // in_ready comes straight from the pending flag, so there is no
  // combinational path from in_valid back to in_ready. A load and an accept
  // are mutually exclusive: a load needs the buffer full, an accept needs it
  // empty. An accept on a wrap cycle therefore only fills pending and waits
  // for the next wrap.
  // -------------------------------------------------------------------------
  assign w_wrap   = (r_cnt == CNT_LAST);
  assign w_accept = s_if.in_valid & ~r_pending_full;
  assign w_load   = w_wrap & r_pending_full;

  assign s_if.in_ready = ~r_pending_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_duty         <= DUTY_MID;
      r_pending      <= DUTY_MID;
      r_pending_full <= 1'b0;
      r_pwm          <= 1'b0;
      r_taken        <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + WIDTH'(1);
      // Compare uses this cycle's cnt/duty; the pin shows it one cycle later.
      r_pwm   <= (r_cnt < r_duty);
      r_taken <= w_load;

      if (w_load) begin
        r_duty         <= r_pending;
        r_pending_full <= 1'b0;
      end else if (w_accept) begin
        r_pending      <= w_offset;
        r_pending_full <= 1'b1;
      end
    end
  end

  assign pwm_out      = r_pwm;
  assign sample_taken = r_taken;
  assign duty         = r_duty;

endmodule
